// File: rtl/shift_add_mult_ctrl_pkg.sv
// Shared definitions for the shift-and-add multiplier controller.
package shift_add_mult_ctrl_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // State-decoded strobes. sel_sum is left out because it depends on b_lsb.
    typedef struct packed {
        logic ld_a;
        logic ld_b;
        logic clr_acc;
        logic ld_acc;
        logic sh_b;
        logic busy;
        logic done;
    } strobes_t;

    // Iteration counter width; a one-bit minimum keeps WIDTH=1 legal.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/shift_add_mult_ctrl_if.sv
// Handshake and datapath strobe bundle between the wrapper/datapath and the controller.
interface shift_add_mult_ctrl_if;

    logic start;
    logic b_lsb;
    logic ld_A;
    logic ld_B;
    logic clr_ACC;
    logic ld_ACC;
    logic sh_B;
    logic sel_sum;
    logic busy;
    logic done;

    // Wrapper / datapath side.
    modport master (
        output start,
        output b_lsb,
        input  ld_A,
        input  ld_B,
        input  clr_ACC,
        input  ld_ACC,
        input  sh_B,
        input  sel_sum,
        input  busy,
        input  done
    );

    // Controller side.
    modport slave (
        input  start,
        input  b_lsb,
        output ld_A,
        output ld_B,
        output clr_ACC,
        output ld_ACC,
        output sh_B,
        output sel_sum,
        output busy,
        output done
    );

endinterface

// File: rtl/shift_add_mult_ctrl_iter_counter.sv
// Loadable down-counter with a zero flag. It saturates at zero rather than wrapping.
module shift_add_mult_ctrl_iter_counter #(
    parameter int CNT_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins over decrement; hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequencing FSM for the shift-and-add multiplier datapath.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  IDLE   | waiting for start; all strobes low
//  LOAD   | load A and B, clear ACC, preset iteration counter
//  RUN    | one add/shift per cycle, WIDTH cycles; sel_sum follows b_lsb
//  DONE   | one-cycle done pulse; {ACC,B} holds the product
module shift_add_mult_ctrl
    import shift_add_mult_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    shift_add_mult_ctrl_if.slave  ctrl_if
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t   state_q;
    state_t   state_d;
    strobes_t strb;
    logic     cnt_zero;
    logic     cnt_load;
    logic     cnt_dec;

    assign cnt_load = (state_q == S_LOAD);
    assign cnt_dec  = (state_q == S_RUN);

    shift_add_mult_ctrl_iter_counter #(
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .load_i     (cnt_load),
        .load_val_i (CNT_LAST),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // State register; reset overrides every state, including mid-RUN.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only looked at in IDLE, so it is never queued.
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = ctrl_if.start ? S_LOAD : S_IDLE;
            S_LOAD:  state_d = S_RUN;
            S_RUN:   state_d = cnt_zero ? S_DONE : S_RUN;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: everything except sel_sum comes from state alone.
    always_comb begin
        strb            = '0;
        ctrl_if.sel_sum = 1'b0;
        case (state_q)
            S_LOAD: begin
                strb.ld_a    = 1'b1;
                strb.ld_b    = 1'b1;
                strb.clr_acc = 1'b1;
                strb.busy    = 1'b1;
            end
            S_RUN: begin
                strb.ld_acc     = 1'b1;
                strb.sh_b       = 1'b1;
                strb.busy       = 1'b1;
                ctrl_if.sel_sum = ctrl_if.b_lsb;
            end
            S_DONE: begin
                strb.done = 1'b1;
                strb.busy = 1'b1;
            end
            default: begin
                strb = '0;
            end
        endcase
    end

    assign ctrl_if.ld_A    = strb.ld_a;
    assign ctrl_if.ld_B    = strb.ld_b;
    assign ctrl_if.clr_ACC = strb.clr_acc;
    assign ctrl_if.ld_ACC  = strb.ld_acc;
    assign ctrl_if.sh_B    = strb.sh_b;
    assign ctrl_if.busy    = strb.busy;
    assign ctrl_if.done    = strb.done;

endmodule
